// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and widths for the instruction fetch stage.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = XLEN - 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO with synchronous clear; head word is presented
// combinationally from storage so a new entry is visible the cycle after its push.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is allowed only when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign valid   = (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order word reads for pc_in under a credit limit,
// tags responses with their PC and buffers them for decode; flush drops in-flight data.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_advance,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   drop_cnt;
  logic [CNT_W-1:0]   tag_count;
  logic [CNT_W-1:0]   buf_count;
  logic               tag_valid;
  logic [TAG_W-1:0]   tag_head;
  logic [ENTRY_W-1:0] buf_rdata;
  fetch_entry_t       head;
  fetch_entry_t       rsp_entry;
  logic [SUM_W-1:0]   credit_used;
  logic               accept;
  logic               pop;
  logic               rsp_fire;
  logic               rsp_keep;
  logic               unused_pc_lsb;

  // A slot freed by decode this cycle can be re-issued immediately (zero-bubble).
  assign pop            = inst_valid && inst_ready;
  assign credit_used    = SUM_W'(outstanding) + SUM_W'(buf_count) - SUM_W'(pop);
  assign imem_req_valid = rst_n && !flush && (credit_used < SUM_W'(DEPTH));
  assign accept         = imem_req_valid && imem_req_ready;
  assign pc_advance     = accept;
  assign imem_addr      = {pc_in[XLEN-1:2], 2'b00};
  assign unused_pc_lsb  = ^pc_in[1:0];

  // Responses with nothing outstanding are ignored; stale ones are burned off drop_cnt.
  assign rsp_fire  = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep  = rsp_fire && (drop_cnt == '0) && !flush;
  assign rsp_entry = '{pc: {tag_head, 2'b00}, instr: imem_rsp_data};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TAG_W),
    .CNT_W (CNT_W)
  ) u_tag_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (accept),
    .wdata (pc_in[XLEN-1:2]),
    .pop   (rsp_keep),
    .rdata (tag_head),
    .valid (tag_valid),
    .count (tag_count)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_inst_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (rsp_keep),
    .wdata (rsp_entry),
    .pop   (pop),
    .rdata (buf_rdata),
    .valid (inst_valid),
    .count (buf_count)
  );

  assign head      = fetch_entry_t'(buf_rdata);
  assign inst_data = head.instr;
  assign inst_pc   = head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp_fire);
      if (flush) begin
        drop_cnt <= outstanding - CNT_W'(rsp_fire);
      end else if (rsp_fire && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  a_rsp_has_credit: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding != '0));

  a_keep_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_keep |-> tag_valid);

  a_tag_tracks_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    (SUM_W'(tag_count) + SUM_W'(drop_cnt)) == SUM_W'(outstanding));

  a_buf_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    buf_count <= CNT_W'(DEPTH));

endmodule
